// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 host transmit and receive paths.
//   state_t     - host transmit FSM states
//   PARITY_EDGE - falling-edge index after which the parity bit is driven
//   STOP_EDGE   - falling-edge index after which the line is released (stop bit)
//   EDGE_W      - width of the frame edge counter
//   odd_parity  - odd-parity bit for a data byte
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_DATA,
        ST_ACK,
        ST_WAIT_IDLE
    } state_t;

    localparam int PARITY_EDGE = 9;
    localparam int STOP_EDGE   = 10;
    localparam int EDGE_W      = $clog2(STOP_EDGE) + 1;

    // Parity bit that makes the total number of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// ps2_sync: brings the raw PS/2 clock and data pins into the clk domain and
// flags falling edges of the synchronized PS/2 clock.
//   clk       in  system clock
//   reset     in  synchronous, active-low reset
//   clk_pin   in  raw asynchronous PS/2 clock pin
//   data_pin  in  raw asynchronous PS/2 data pin
//   clk_sync  out synchronized PS/2 clock level
//   data_sync out synchronized PS/2 data level
//   clk_fe    out one-cycle flag: synchronized PS/2 clock went 1 -> 0
module ps2_sync (
    input  logic clk,
    input  logic reset,
    input  logic clk_pin,
    input  logic data_pin,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fe
);

    logic clk_meta;
    logic data_meta;
    logic clk_prev;

    // Registers reset to 1 (the idle level of an open-drain line) so that
    // leaving reset never fabricates a falling edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= clk_pin;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= data_pin;
            data_sync <= data_meta;
        end
    end

    assign clk_fe = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter. Sends one command byte over
// the open-drain PS/2 clock/data lines: inhibit, request-to-send, 8 data bits
// LSB first, odd parity, stop, then samples the device ack.
// Handshake: a byte is accepted on a cycle where tx_valid & tx_ready are both
// high; tx_ready is high only in IDLE, and tx_valid while busy is dropped.
//   clk          in  system clock
//   reset        in  synchronous, active-low reset
//   tx_data      in  command byte to send
//   tx_valid     in  request to send tx_data
//   tx_ready     out high only in IDLE
//   busy         out high in every state except IDLE
//   done         out one-cycle pulse: frame complete, ack = 0
//   ack_err      out one-cycle pulse: frame complete, ack sampled 1
//   timeout      out one-cycle pulse: frame aborted after TIMEOUT_CYCLES
//   ps2_clk_in   in  raw PS/2 clock pin
//   ps2_data_in  in  raw PS/2 data pin
//   ps2_clk_oe   out 1 = pull PS/2 clock low
//   ps2_data_oe  out 1 = pull PS/2 data low
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [INH_W-1:0]  INH_LAST   = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LIMIT   = TO_W'(TIMEOUT_CYCLES);
    localparam logic [EDGE_W-1:0] LAST_DATA  = EDGE_W'(8);
    localparam logic [EDGE_W-1:0] PAR_EDGE_V = EDGE_W'(PARITY_EDGE);

    logic clk_sync;
    logic data_sync;
    logic clk_fe;

    ps2_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .clk_pin   (ps2_clk_in),
        .data_pin  (ps2_data_in),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .clk_fe    (clk_fe)
    );

    state_t            state_q,  state_d;
    logic [INH_W-1:0]  inh_q,    inh_d;
    logic [TO_W-1:0]   to_q,     to_d;
    logic [EDGE_W-1:0] edge_q,   edge_d;
    logic [EDGE_W-1:0] edge_next;
    logic [7:0]        data_q,   data_d;
    logic              par_q,    par_d;
    logic              doe_q,    doe_d;
    logic              in_frame;
    logic              tmo_hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            inh_q   <= '0;
            to_q    <= '0;
            edge_q  <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            doe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inh_q   <= inh_d;
            to_q    <= to_d;
            edge_q  <= edge_d;
            data_q  <= data_d;
            par_q   <= par_d;
            doe_q   <= doe_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        inh_d       = inh_q;
        to_d        = to_q;
        edge_d      = edge_q;
        data_d      = data_q;
        par_d       = par_q;
        doe_d       = doe_q;
        tx_ready    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        ack_err     = 1'b0;
        timeout     = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        edge_next   = edge_q + 1'b1;

        in_frame = (state_q == ST_REQ) || (state_q == ST_DATA) || (state_q == ST_ACK);
        tmo_hit  = in_frame && (to_q == TO_LIMIT);

        case (state_q)
            ST_IDLE: begin
                busy     = 1'b0;
                tx_ready = 1'b1;
                doe_d    = 1'b0;
                if (tx_valid) begin
                    data_d  = tx_data;
                    par_d   = odd_parity(tx_data);
                    inh_d   = '0;
                    to_d    = '0;
                    edge_d  = '0;
                    state_d = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (inh_q == INH_LAST) begin
                    // Entering REQ: pulling data low here is the start bit.
                    state_d = ST_REQ;
                    to_d    = '0;
                    edge_d  = '0;
                    doe_d   = 1'b1;
                end else begin
                    inh_d = inh_q + 1'b1;
                end
            end

            ST_REQ, ST_DATA: begin
                ps2_data_oe = doe_q;
                if (to_q != TO_LIMIT) begin
                    to_d = to_q + 1'b1;
                end
                if (clk_fe) begin
                    edge_d  = edge_next;
                    state_d = ST_DATA;
                    if (edge_next <= LAST_DATA) begin
                        // Edge k (1..8) puts data bit k-1, i.e. edge_q, on the line.
                        doe_d = ~data_q[edge_q[2:0]];
                    end else if (edge_next == PAR_EDGE_V) begin
                        doe_d = ~par_q;
                    end else begin
                        // STOP_EDGE: release data for the stop bit.
                        doe_d   = 1'b0;
                        state_d = ST_ACK;
                    end
                end
            end

            ST_ACK: begin
                if (to_q != TO_LIMIT) begin
                    to_d = to_q + 1'b1;
                end
                if (clk_fe) begin
                    if (data_sync) begin
                        ack_err = 1'b1;
                    end else begin
                        done = 1'b1;
                    end
                    state_d = ST_WAIT_IDLE;
                end
            end

            ST_WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Timeout overrides everything in the frame states, including an ack
        // edge landing in the same cycle, so the three pulses stay exclusive.
        if (tmo_hit) begin
            timeout     = 1'b1;
            done        = 1'b0;
            ack_err     = 1'b0;
            ps2_data_oe = 1'b0;
            doe_d       = 1'b0;
            state_d     = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 4000;
    localparam int HALF = 40;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       dev_clk_low;
    logic       dev_data_low;
    logic       clk_line;
    logic       data_line;

    int checks = 0;
    int errors = 0;

    int done_cnt  = 0;
    int aerr_cnt  = 0;
    int tmo_cnt   = 0;
    int multi_cnt = 0;
    int oe_run    = 0;
    int last_run  = 0;

    // Open-drain wired-AND bus between host and device model.
    assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .timeout     (timeout),
        .ps2_clk_in  (clk_line),
        .ps2_data_in (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse and inhibit-length monitor
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (ack_err === 1'b1) aerr_cnt++;
        if (timeout === 1'b1) tmo_cnt++;
        if ((int'(done === 1'b1) + int'(ack_err === 1'b1) + int'(timeout === 1'b1)) > 1) multi_cnt++;
        if (ps2_clk_oe === 1'b1) begin
            oe_run++;
        end else if (oe_run != 0) begin
            last_run = oe_run;
            oe_run   = 0;
        end
    end

    // Watchdog
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic accept(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL accept_wait: tx_ready=%b required 1 within 2000 cycles", tx_ready);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        checks++;
        if (ps2_clk_oe !== 1'b1) begin
            errors++;
            $display("FAIL accept_to_bus: clk_oe=%b required 1 one cycle after accept", ps2_clk_oe);
        end
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 200);
    endtask

    // Device model: samples the data line at the end of each high half-period,
    // then pulls clk low; 11 falling edges, optional ack on the last one.
    task automatic dev_frame(input bit give_ack, output logic [10:0] smp, output bit ok);
        smp = '0;
        wait_req(ok);
        if (!ok) return;
        for (int i = 0; i < 11; i++) begin
            repeat (HALF) @(negedge clk);
            smp[i] = data_line;
            if (i == 10 && give_ack) begin
                dev_data_low = 1'b1;
                @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (tx_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL wait_idle: tx_ready=%b required 1 within 1000 cycles", tx_ready);
        end
    endtask

    // Tests
    task automatic test_reset();
        int d0;
        int a0;
        int t0;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_oe: clk_oe=%b data_oe=%b required 0 0", ps2_clk_oe, ps2_data_oe);
        end
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: tx_ready=%b busy=%b required 1 0", tx_ready, busy);
        end
        checks++;
        if (done !== 1'b0 || ack_err !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: done=%b ack_err=%b timeout=%b required 0 0 0", done, ack_err, timeout);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Reset in the middle of INHIBIT.
        d0 = done_cnt;
        a0 = aerr_cnt;
        t0 = tmo_cnt;
        accept(8'hED);
        repeat (5) @(negedge clk);
        checks++;
        if (ps2_clk_oe !== 1'b1) begin
            errors++;
            $display("FAIL mid_inhibit: clk_oe=%b required 1", ps2_clk_oe);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_frame: clk_oe=%b data_oe=%b tx_ready=%b busy=%b required 0 0 1 0",
                     ps2_clk_oe, ps2_data_oe, tx_ready, busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (ps2_clk_oe !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_resume: clk_oe=%b busy=%b required 0 0", ps2_clk_oe, busy);
        end
        checks++;
        if (done_cnt != d0 || aerr_cnt != a0 || tmo_cnt != t0) begin
            errors++;
            $display("FAIL reset_no_pulse: done=%0d ack_err=%0d timeout=%0d new pulses, required 0 0 0",
                     done_cnt - d0, aerr_cnt - a0, tmo_cnt - t0);
        end
    endtask

    task automatic test_send(input logic [7:0] d, input logic par);
        logic [10:0] smp;
        logic [10:0] exp_bits;
        bit          ok;
        int          d0;
        int          a0;
        d0 = done_cnt;
        a0 = aerr_cnt;
        exp_bits = {1'b1, par, d, 1'b0};
        accept(d);
        dev_frame(1'b1, smp, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_req_%02h: request-to-send not seen within 200 cycles", d);
        end
        checks++;
        if (smp !== exp_bits) begin
            errors++;
            $display("FAIL send_bits_%02h: device saw %b required %b (stop..start)", d, smp, exp_bits);
        end
        wait_idle();
        checks++;
        if (last_run != INH) begin
            errors++;
            $display("FAIL inhibit_len_%02h: clk_oe high %0d cycles required %0d", d, last_run, INH);
        end
        checks++;
        if (done_cnt != d0 + 1 || aerr_cnt != a0) begin
            errors++;
            $display("FAIL send_done_%02h: done pulses %0d ack_err pulses %0d required 1 0",
                     d, done_cnt - d0, aerr_cnt - a0);
        end
        checks++;
        if (busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL send_idle_%02h: busy=%b clk_oe=%b data_oe=%b required 0 0 0",
                     d, busy, ps2_clk_oe, ps2_data_oe);
        end
    endtask

    task automatic test_ack_err();
        logic [10:0] smp;
        bit          ok;
        int          d0;
        int          a0;
        d0 = done_cnt;
        a0 = aerr_cnt;
        accept(8'h55);
        dev_frame(1'b0, smp, ok);
        checks++;
        if (smp !== 11'b11_0101_0101_0) begin
            errors++;
            $display("FAIL ack_err_bits: device saw %b required %b", smp, 11'b11_0101_0101_0);
        end
        wait_idle();
        checks++;
        if (aerr_cnt != a0 + 1 || done_cnt != d0) begin
            errors++;
            $display("FAIL ack_err_pulse: ack_err pulses %0d done pulses %0d required 1 0",
                     aerr_cnt - a0, done_cnt - d0);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        int d0;
        int a0;
        int t0;
        d0 = done_cnt;
        a0 = aerr_cnt;
        t0 = tmo_cnt;
        accept(8'hA5);
        wait_req(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout_req: request-to-send not seen within 200 cycles");
        end
        n = 0;
        while (timeout !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != TMO) begin
            errors++;
            $display("FAIL timeout_latency: pulse %0d cycles after REQ required %0d", n, TMO);
        end
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL timeout_release: clk_oe=%b data_oe=%b required 0 0", ps2_clk_oe, ps2_data_oe);
        end
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: tx_ready=%b busy=%b data_oe=%b required 1 0 0",
                     tx_ready, busy, ps2_data_oe);
        end
        checks++;
        if (tmo_cnt != t0 + 1 || done_cnt != d0 || aerr_cnt != a0) begin
            errors++;
            $display("FAIL timeout_pulses: timeout %0d done %0d ack_err %0d required 1 0 0",
                     tmo_cnt - t0, done_cnt - d0, aerr_cnt - a0);
        end
    endtask

    task automatic test_busy();
        logic [10:0] smp;
        bit          ok;
        bit          seen;
        int          d0;
        d0 = done_cnt;
        seen = 1'b0;
        accept(8'h3C);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        fork
            dev_frame(1'b1, smp, ok);
            begin
                int n = 0;
                while (done !== 1'b1 && n < 3000) begin
                    @(negedge clk);
                    n++;
                end
                seen = (n < 3000);
                tx_valid = 1'b0;
            end
        join
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL busy_done_seen: done pulse not seen within 3000 cycles");
        end
        checks++;
        if (smp !== 11'b11_0011_1100_0) begin
            errors++;
            $display("FAIL busy_bits: device saw %b required %b", smp, 11'b11_0011_1100_0);
        end
        wait_idle();
        repeat (50) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignored: busy=%b clk_oe=%b required 0 0", busy, ps2_clk_oe);
        end
        checks++;
        if (done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL busy_one_done: done pulses %0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (multi_cnt != 0) begin
            errors++;
            $display("FAIL pulse_exclusive: %0d cycles with overlapping pulses required 0", multi_cnt);
        end
    endtask

    initial begin
        reset        = 1'b0;
        tx_data      = 8'h00;
        tx_valid     = 1'b0;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;

        test_reset();
        test_send(8'hED, 1'b1);
        test_send(8'h07, 1'b0);
        test_send(8'h00, 1'b1);
        test_ack_err();
        test_timeout();
        test_busy();
        test_exclusive();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
